// File: rtl/sequential_booth_multiplier.sv
// Multi-cycle radix-4 Booth multiplier for signed or unsigned operands.
// Each CALC cycle retires one Booth digit; the product is registered when the FSM enters DONE.
module sequential_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
);

  localparam int EW    = WIDTH + 2;
  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = EW / 2;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   acc, acc_nxt, mcand, term;
  logic [EW-1:0]   mplier;
  logic            prev;
  logic [CW-1:0]   count;
  logic            accept, last_step;
  logic [PW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;

  assign accept    = start && (state != CALC);
  assign last_step = (count == CW'(STEPS - 1));

  // Accumulating modulo 2^(2*WIDTH) is exact: the true product always fits in 2*WIDTH bits.
  assign a_ext = is_signed ? {{(PW-WIDTH){a[WIDTH-1]}}, a} : {{(PW-WIDTH){1'b0}}, a};
  assign b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  always_comb begin
    term = '0;
    case ({mplier[1:0], prev})
      3'b001, 3'b010: term = mcand;
      3'b011:         term = mcand << 1;
      3'b100:         term = -(mcand << 1);
      3'b101, 3'b110: term = -mcand;
      default:        term = '0;
    endcase
    acc_nxt = acc + term;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplicand moves left by two each step while the multiplier window moves right.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prev   <= 1'b0;
      count  <= '0;
      result <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= a_ext;
      mplier <= b_ext;
      prev   <= 1'b0;
      count  <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 2;
      mplier <= mplier >> 2;
      prev   <= mplier[1];
      count  <= count + 1'b1;
      if (last_step) result <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_sequential_booth_multiplier.sv
// Self-checking bench for sequential_booth_multiplier at WIDTH=32: directed table,
// random operands against an arithmetic model, and multi-cycle corner sequences.
module tb_sequential_booth_multiplier;

  localparam int W   = 32;
  localparam int LAT = W / 2 + 2;
  localparam int BSY = W / 2 + 1;

  logic            clk = 1'b0;
  logic            rst, start, is_signed;
  logic [W-1:0]    a, b;
  logic [2*W-1:0]  result;
  logic            done, busy;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string        name;
    logic         sgn;
    logic [31:0]  x;
    logic [31:0]  y;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[$];

  sequential_booth_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] refProduct(logic sgn, logic [31:0] x, logic [31:0] y);
    longint sx, sy;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic applyStimulus(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; is_signed = sgn; a = x; b = y;
    tick();
    start = 1'b0; is_signed = ~sgn; a = $urandom; b = $urandom;
  endtask

  // Ticks until done is seen (bounded); returns ticks taken and busy cycles observed.
  task automatic waitDone(output int ticks, output int bcount);
    ticks = 0; bcount = 0;
    while (!done && ticks < 200) begin
      if (busy) bcount++;
      tick();
      ticks++;
    end
  endtask

  task automatic runOp(input string name, input logic sgn, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp, input bit timing);
    int t, bc;
    applyStimulus(sgn, x, y);
    waitDone(t, bc);
    checkOutput({name, " product"}, result, exp);
    if (timing) begin
      checkOutput({name, " latency"}, 64'(t + 1), 64'(LAT));
      checkOutput({name, " busy cycles"}, 64'(bc), 64'(BSY));
      tick();
      checkOutput({name, " done width"}, 64'(done), 64'(0));
      checkOutput({name, " result hold"}, result, exp);
    end else begin
      tick();
    end
  endtask

  initial begin
    int t, bc, ndone;
    logic [31:0] x, y, nx, ny;
    logic        s, ns;
    logic [63:0] exp;

    vecs.push_back('{"s -1*-1",     1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001});
    vecs.push_back('{"u max*max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
    vecs.push_back('{"s min*min",   1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000});
    vecs.push_back('{"s max*min",   1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000});
    vecs.push_back('{"u 0*max",     1'b0, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000});
    vecs.push_back('{"s 3*-5",      1'b1, 32'h00000003, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1});
    vecs.push_back('{"u 2*3",       1'b0, 32'h00000002, 32'h00000003, 64'h0000000000000006});
    vecs.push_back('{"u min*min",   1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000});

    rst = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    tick(); tick();
    checkOutput("reset result", result, 64'(0));
    checkOutput("reset done", 64'(done), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    rst = 1'b1;
    tick();

    foreach (vecs[i]) runOp(vecs[i].name, vecs[i].sgn, vecs[i].x, vecs[i].y, vecs[i].exp, 1'b1);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom); x = $urandom; y = $urandom;
      runOp("random", s, x, y, refProduct(s, x, y), (i % 10) == 0);
    end

    // Back-to-back: start stays high, next operands presented during each DONE cycle.
    s = 1'b1; x = $urandom; y = $urandom;
    start = 1'b1; is_signed = s; a = x; b = y;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp = refProduct(s, x, y);
      a = $urandom; b = $urandom;
      waitDone(t, bc);
      checkOutput("b2b product", result, exp);
      checkOutput("b2b spacing", 64'(t + 1), 64'(LAT));
      ns = 1'($urandom); nx = $urandom; ny = $urandom;
      is_signed = ns; a = nx; b = ny;
      if (k == 3) start = 1'b0;
      tick();
      checkOutput("b2b no idle", 64'(busy), (k == 3) ? 64'(0) : 64'(1));
      s = ns; x = nx; y = ny;
    end
    tick();

    // Start pulsed during CALC with different operands must be ignored.
    applyStimulus(1'b1, 32'hFFFF1234, 32'h00005678);
    tick(); tick();
    start = 1'b1; is_signed = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
    tick();
    start = 1'b0;
    waitDone(t, bc);
    checkOutput("calc start ignored", result, refProduct(1'b1, 32'hFFFF1234, 32'h00005678));
    checkOutput("calc start latency", 64'(t + 4), 64'(LAT));
    tick();

    // Reset for one cycle in the eighth CALC cycle aborts without a done pulse.
    applyStimulus(1'b0, 32'h12345678, 32'h9ABCDEF0);
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("abort result", result, 64'(0));
    checkOutput("abort busy", 64'(busy), 64'(0));
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) ndone++;
      tick();
    end
    checkOutput("abort no done", 64'(ndone), 64'(0));
    runOp("after abort", 1'b1, 32'h00001000, 32'hFFFFF000, refProduct(1'b1, 32'h00001000, 32'hFFFFF000), 1'b1);

    // Reset and start at the same edge: reset wins.
    rst = 1'b0; start = 1'b1; a = 32'h5; b = 32'h7;
    tick();
    rst = 1'b1; start = 1'b0;
    checkOutput("reset priority busy", 64'(busy), 64'(0));

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
